// File: rtl/ifetch_queue.sv
//-----------------------------------------------------------------------------
// ifetch_queue
//   Instruction fetch unit with a 4-entry prefetch FIFO.
//
//   A three-state fetch FSM issues one memory request at a time and pushes
//   each returned word, tagged with its PC, into the FIFO. The decoder
//   consumes the head entry whenever it is not stalled. A redirect
//   (jump_en) flushes the FIFO, retargets the fetch PC, and drops any
//   response still in flight.
//
//   Build option:
//     IFETCH_JAL_PREDICT_EN - when defined, a fetched JAL redirects the next
//                             fetch to its target instead of pc + 4.
//
//   Ports:
//     clk, rst       clock, asynchronous active-low reset
//     rdy            global enable; low freezes all state
//     mem_req        fetch request valid (held until mem_done)
//     mem_addr       word-aligned fetch address
//     mem_done       single-cycle response strobe
//     mem_instr      fetched word
//     IF_success     head entry consumed this cycle
//     instr          head instruction
//     instr_pc       head PC
//     stall_RS       downstream cannot accept
//     jump_en        flush and redirect
//     jump_pc        redirect target
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ifetch_queue #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   output logic              mem_req,
   output logic [DATA_W-1:0] mem_addr,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_instr,
   output logic              IF_success,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] instr_pc,
   input  logic              stall_RS,
   input  logic              jump_en,
   input  logic [DATA_W-1:0] jump_pc
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [DATA_W-1:0] req_addr_q;
   logic [1:0]        head_q, tail_q;
   logic [2:0]        count_q, count_d;

   logic [DATA_W-1:0] fifo_pc    [4];
   logic [DATA_W-1:0] fifo_instr [4];

   logic push, pop, flush, issue;

   function automatic logic [DATA_W-1:0] seq_pc(input logic [DATA_W-1:0] pc);
      return pc + DATA_W'(4);
   endfunction

`ifdef IFETCH_JAL_PREDICT_EN
   // A JAL fetched at pc steers the next fetch straight to its target.
   function automatic logic [DATA_W-1:0] pred_pc(input logic [DATA_W-1:0] pc,
                                                 input logic [DATA_W-1:0] iw);
      logic signed [20:0] j_imm;
      j_imm = {iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
      if (iw[6:0] == 7'b1101111)
         return pc + {{(DATA_W-21){j_imm[20]}}, j_imm};
      else
         return seq_pc(pc);
   endfunction
`endif

   assign pop        = rdy & (count_q != 3'd0) & ~stall_RS & ~jump_en;
   assign IF_success = pop;
   assign instr      = fifo_instr[head_q];
   assign instr_pc   = fifo_pc[head_q];

   assign mem_req  = (state_q == BUSY) || (state_q == DISCARD);
   // The in-flight address stays put even if a redirect retargets fetch_pc.
   assign mem_addr = (state_q == IDLE) ? fetch_pc_q : req_addr_q;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      push       = 1'b0;
      flush      = 1'b0;
      issue      = 1'b0;
      if (rdy) begin
         unique case (state_q)
            IDLE: begin
               if (!jump_en && (count_q < 3'd4)) begin
                  state_d = BUSY;
                  issue   = 1'b1;
               end
            end
            BUSY: begin
               if (jump_en) begin
                  // A response landing with the redirect is dropped.
                  state_d = mem_done ? IDLE : DISCARD;
               end else if (mem_done) begin
                  push    = 1'b1;
                  state_d = IDLE;
`ifdef IFETCH_JAL_PREDICT_EN
                  fetch_pc_d = pred_pc(fetch_pc_q, mem_instr);
`else
                  fetch_pc_d = seq_pc(fetch_pc_q);
`endif
               end
            end
            DISCARD: begin
               if (mem_done) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         if (jump_en) begin
            flush      = 1'b1;
            fetch_pc_d = jump_pc;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (flush)
         count_d = 3'd0;
      else
         count_d = count_q + {2'b00, push} - {2'b00, pop};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= '0;
         req_addr_q <= '0;
         head_q     <= 2'd0;
         tail_q     <= 2'd0;
         count_q    <= 3'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         if (issue) req_addr_q <= fetch_pc_q;
         if (flush) begin
            head_q <= 2'd0;
            tail_q <= 2'd0;
         end else begin
            if (pop)  head_q <= head_q + 2'd1;
            if (push) tail_q <= tail_q + 2'd1;
         end
      end
   end

   // FIFO payload needs no reset; occupancy is tracked by count/head/tail.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[tail_q]    <= fetch_pc_q;
         fifo_instr[tail_q] <= mem_instr;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
`timescale 1ns/1ps

module tb_ifetch_queue;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_instr;
   logic        IF_success;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        stall_RS;
   logic        jump_en;
   logic [31:0] jump_pc;

   // memory-side drive: automatic responder or manual directed values
   logic        auto_mem;
   logic        auto_done;
   logic [31:0] auto_instr;
   logic        man_done;
   logic [31:0] man_instr;

   int n_vec;
   int n_err;

`ifdef IFETCH_JAL_PREDICT_EN
   localparam logic [31:0] JAL_NEXT = 32'h0000_0020;
`else
   localparam logic [31:0] JAL_NEXT = 32'h0000_0024;
`endif

   assign mem_done  = auto_mem ? auto_done  : man_done;
   assign mem_instr = auto_mem ? auto_instr : man_instr;

   ifetch_queue dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_done   (mem_done),
      .mem_instr  (mem_instr),
      .IF_success (IF_success),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .stall_RS   (stall_RS),
      .jump_en    (jump_en),
      .jump_pc    (jump_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // non-JAL word tagged with its address (opcode 0010011)
   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // 1-cycle-latency responder
   initial begin
      auto_done  = 1'b0;
      auto_instr = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_mem) begin
            if (mem_req && !auto_done) begin
               auto_done  = 1'b1;
               auto_instr = word(mem_addr);
            end else begin
               auto_done = 1'b0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b0; rdy = 1'b1; stall_RS = 1'b0; jump_en = 1'b0; jump_pc = 32'h0;
      auto_mem = 1'b0; man_done = 1'b0; man_instr = 32'h0;

      // reset state
      tick(); tick();
      chk(32'(mem_req), 32'd0, "rst_mem_req");
      chk(mem_addr, 32'h0, "rst_mem_addr");
      chk(32'(IF_success), 32'd0, "rst_if_success");
      rst = 1'b1; auto_mem = 1'b1;

      // streaming fetch 0x0, 0x4, 0x8
      tick(); chk(32'(mem_req), 32'd1, "seq_req0"); chk(mem_addr, 32'h0, "seq_addr0");
              chk(32'(IF_success), 32'd0, "seq_if0_idle");
      tick(); chk(32'(mem_req), 32'd0, "seq_req_gap0"); chk(32'(IF_success), 32'd1, "seq_if0");
              chk(instr_pc, 32'h0, "seq_pc0"); chk(instr, word(32'h0), "seq_instr0");
      tick(); chk(32'(mem_req), 32'd1, "seq_req1"); chk(mem_addr, 32'h4, "seq_addr1");
      tick(); chk(32'(IF_success), 32'd1, "seq_if1"); chk(instr_pc, 32'h4, "seq_pc1");
      tick(); chk(32'(mem_req), 32'd1, "seq_req2"); chk(mem_addr, 32'h8, "seq_addr2");
      tick(); chk(32'(IF_success), 32'd1, "seq_if2"); chk(instr_pc, 32'h8, "seq_pc2");

      // stall: fill to 4 and stop requesting
      tick(); chk(mem_addr, 32'hC, "stall_addr_c");
      stall_RS = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk(32'(mem_req), 32'd0, "full_req");
      chk(32'(IF_success), 32'd0, "full_if");
      chk(instr_pc, 32'hC, "full_head_pc");
      for (int i = 0; i < 12; i++) begin
         tick();
         chk(32'(mem_req), 32'd0, "full_no_5th_req");
         chk(32'(IF_success), 32'd0, "full_no_pop");
      end
      stall_RS = 1'b0;
      #1;
      chk(32'(IF_success), 32'd1, "drain_if0"); chk(instr_pc, 32'hC, "drain_pc0");
      tick(); chk(32'(IF_success), 32'd1, "drain_if1"); chk(instr_pc, 32'h10, "drain_pc1");
              chk(32'(mem_req), 32'd0, "drain_no_req_at_full");
      tick(); chk(32'(IF_success), 32'd1, "drain_if2"); chk(instr_pc, 32'h14, "drain_pc2");
              chk(32'(mem_req), 32'd1, "drain_refill_req"); chk(mem_addr, 32'h1C, "drain_refill_addr");
      tick(); chk(32'(IF_success), 32'd1, "drain_if3"); chk(instr_pc, 32'h18, "drain_pc3");
      auto_mem = 1'b0;
      tick(); chk(32'(mem_req), 32'd1, "busy20_req"); chk(mem_addr, 32'h20, "busy20_addr");
              chk(instr_pc, 32'h1C, "drain_pc4");
      tick(); chk(32'(IF_success), 32'd0, "empty_if");

      // get to BUSY at 0x10 via a redirect
      jump_en = 1'b1; jump_pc = 32'h10;
      tick(); jump_en = 1'b0;
      chk(32'(mem_req), 32'd1, "discard_req");
      man_done = 1'b1; man_instr = word(32'h20);
      tick(); man_done = 1'b0;
      chk(32'(mem_req), 32'd0, "discard_to_idle");
      chk(32'(IF_success), 32'd0, "discard_no_push");

      // jump while BUSY at 0x10 -> response dropped, refetch 0x100
      tick(); chk(32'(mem_req), 32'd1, "busy10_req"); chk(mem_addr, 32'h10, "busy10_addr");
      jump_en = 1'b1; jump_pc = 32'h100;
      #1 chk(32'(IF_success), 32'd0, "jump_if_low");
      tick(); jump_en = 1'b0;
      chk(32'(mem_req), 32'd1, "jump_discard_req");
      man_done = 1'b1; man_instr = word(32'h10);
      tick(); man_done = 1'b0;
      chk(32'(mem_req), 32'd0, "jump_idle"); chk(32'(IF_success), 32'd0, "jump_fifo_empty");
      tick(); chk(32'(mem_req), 32'd1, "jump_req"); chk(mem_addr, 32'h100, "jump_addr");

      // jump coinciding with mem_done in BUSY
      man_done = 1'b1; man_instr = word(32'h100); jump_en = 1'b1; jump_pc = 32'h200;
      tick(); man_done = 1'b0; jump_en = 1'b0;
      chk(32'(mem_req), 32'd0, "coinc_idle"); chk(32'(IF_success), 32'd0, "coinc_no_push");
      tick(); chk(32'(mem_req), 32'd1, "coinc_req"); chk(mem_addr, 32'h200, "coinc_addr");

      // rdy low for 5 cycles while BUSY with mem_done high
      rdy = 1'b0; man_done = 1'b1; man_instr = word(32'h200);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk(32'(mem_req), 32'd1, "frz_req");
         chk(mem_addr, 32'h200, "frz_addr");
         chk(32'(IF_success), 32'd0, "frz_if");
      end
      rdy = 1'b1; man_done = 1'b0;
      tick(); chk(32'(mem_req), 32'd1, "frz_still_busy"); chk(32'(IF_success), 32'd0, "frz_no_push");
      man_done = 1'b1;
      tick(); man_done = 1'b0;
      chk(32'(IF_success), 32'd1, "unfrz_if"); chk(instr_pc, 32'h200, "unfrz_pc");
      chk(instr, word(32'h200), "unfrz_instr");
      tick(); chk(32'(mem_req), 32'd1, "unfrz_req"); chk(mem_addr, 32'h204, "unfrz_addr");

      // JAL x0,0 fetched at 0x20
      jump_en = 1'b1; jump_pc = 32'h20;
      tick(); jump_en = 1'b0; man_done = 1'b1; man_instr = word(32'h204);
      tick(); man_done = 1'b0;
      tick(); chk(32'(mem_req), 32'd1, "jal_req"); chk(mem_addr, 32'h20, "jal_addr");
      man_done = 1'b1; man_instr = 32'h0000_006F;
      tick(); man_done = 1'b0;
      chk(32'(IF_success), 32'd1, "jal_if"); chk(instr, 32'h0000_006F, "jal_instr");
      chk(instr_pc, 32'h20, "jal_pc");
      tick(); chk(32'(mem_req), 32'd1, "jal_next_req"); chk(mem_addr, JAL_NEXT, "jal_next_addr");

      // PC wrap at 0xFFFFFFFC
      jump_en = 1'b1; jump_pc = 32'hFFFF_FFFC;
      tick(); jump_en = 1'b0; man_done = 1'b1; man_instr = word(32'h0);
      tick(); man_done = 1'b0;
      tick(); chk(mem_addr, 32'hFFFF_FFFC, "wrap_addr_top");
      man_done = 1'b1; man_instr = word(32'hFFFF_FFFC);
      tick(); man_done = 1'b0;
      chk(instr_pc, 32'hFFFF_FFFC, "wrap_pc_top");
      tick(); chk(32'(mem_req), 32'd1, "wrap_req"); chk(mem_addr, 32'h0, "wrap_addr_zero");

      // reset mid-request, stray mem_done after release
      rst = 1'b0;
      #1;
      chk(32'(mem_req), 32'd0, "rst2_req"); chk(mem_addr, 32'h0, "rst2_addr");
      chk(32'(IF_success), 32'd0, "rst2_if");
      tick(); rst = 1'b1; man_done = 1'b1; man_instr = word(32'h44);
      tick(); man_done = 1'b0;
      chk(32'(mem_req), 32'd1, "rst2_new_req"); chk(mem_addr, 32'h0, "rst2_new_addr");
      chk(32'(IF_success), 32'd0, "rst2_stray_ignored");
      tick(); chk(32'(mem_req), 32'd1, "rst2_still_busy");
      chk(32'(IF_success), 32'd0, "rst2_empty");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
